// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver with event FIFO.
// Synchronises and glitch-filters the PS/2 lines on a divided sample tick,
// frames 11-bit packets, folds E0/F0 prefixes into one key event and queues
// events behind a VALID/READY interface.
module ps2_rx_fifo #(
  parameter int CLK_DIV    = 250,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 4000,
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PS2_CLK,
  input  logic          PS2_DATA,
  output logic [7:0]    KEY_CODE,
  output logic          KEY_EXT,
  output logic          KEY_BRK,
  output logic          VALID,
  input  logic          READY,
  output logic          FRAME_ERR,
  output logic          OVERFLOW,
  output logic [AW:0]   LEVEL
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [3:0] RUN_LAST = 4'(FILTER_LEN - 1);
  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronisers (idle bus level is high)
  // ---------------------------------------------------------------------
  logic clk_s1_q, clk_s2_q;
  logic dat_s1_q, dat_s2_q;

  // Two-flop synchronisers on both PS/2 lines.
  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= PS2_CLK;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2_DATA;
      dat_s2_q <= dat_s1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Sample tick divider
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  // Free-running divider; tick is high on its last count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // PS2_CLK run-length filter
  // ---------------------------------------------------------------------
  logic       filt_q, filt_d;
  logic [3:0] run_q, run_d;
  logic       fall;

  // The filtered level only moves after FILTER_LEN consecutive differing ticks.
  always_comb begin
    filt_d = filt_q;
    run_d  = run_q;
    if (tick) begin
      if (clk_s2_q != filt_q) begin
        if (run_q == RUN_LAST) begin
          filt_d = clk_s2_q;
          run_d  = '0;
        end else begin
          run_d = run_q + 4'd1;
        end
      end else begin
        run_d = '0;
      end
    end
  end

  // A fall can only happen on a tick, so data is sampled on that same tick.
  assign fall = filt_q & ~filt_d;

  // Filter state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      filt_q <= 1'b1;
      run_q  <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM and prefix decoder
  // ---------------------------------------------------------------------
  state_t          state_q;
  logic [3:0]      bitcnt_q;
  logic [TO_W-1:0] tcnt_q;
  logic [9:0]      shift_q;   // {stop, parity, D7..D0} once complete
  logic            ext_q;
  logic            brk_q;
  logic            frame_err_q;

  logic       good_w;
  logic [7:0] byte_w;
  logic       push_w;
  logic [9:0] push_word;

  // Frame check and event generation during the single CHECK cycle.
  always_comb begin
    byte_w    = shift_q[7:0];
    good_w    = shift_q[9] & (^shift_q[8:0]);
    push_w    = (state_q == CHECK) && good_w &&
                (byte_w != CODE_EXT) && (byte_w != CODE_BRK);
    push_word = {ext_q, brk_q, byte_w};
  end

  // Receive FSM: start detect, bit shifting with timeout, check and prefix tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      tcnt_q      <= '0;
      shift_q     <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall && !dat_s2_q) begin
            state_q  <= SHIFT;
            bitcnt_q <= '0;
            tcnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (fall) begin
            shift_q  <= {dat_s2_q, shift_q[9:1]};
            tcnt_q   <= '0;
            bitcnt_q <= bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd9) begin
              state_q <= CHECK;
            end
          end else if (tick) begin
            if (tcnt_q == TO_LAST) begin
              state_q     <= IDLE;
              frame_err_q <= 1'b1;
            end else begin
              tcnt_q <= tcnt_q + TO_W'(1);
            end
          end
        end
        CHECK: begin
          state_q <= IDLE;
          if (!good_w) begin
            frame_err_q <= 1'b1;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
          end else if (byte_w == CODE_EXT) begin
            ext_q <= 1'b1;
          end else if (byte_w == CODE_BRK) begin
            brk_q <= 1'b1;
          end else begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          overflow_q;

  logic       pop_w;
  logic       full_w;
  logic       wr_en_w;
  logic [9:0] head_w;

  // At full a simultaneous pop frees the slot being written, so both proceed.
  always_comb begin
    pop_w   = (level_q != '0) && READY;
    full_w  = (level_q == FULL_LVL);
    wr_en_w = push_w && (!full_w || pop_w);
    head_w  = mem_q[rd_ptr_q];
  end

  // Storage array write port.
  always_ff @(posedge CLK) begin
    if (wr_en_w) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  // Pointers, fill level and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en_w) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (wr_en_w && !pop_w) begin
        level_q <= level_q + LW'(1);
      end else if (!wr_en_w && pop_w) begin
        level_q <= level_q - LW'(1);
      end
      if (push_w && full_w && !pop_w) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Head entry is forced to zero while empty so stale array contents never leak.
  assign VALID     = (level_q != '0);
  assign KEY_CODE  = VALID ? head_w[7:0] : 8'h00;
  assign KEY_BRK   = VALID ? head_w[8]   : 1'b0;
  assign KEY_EXT   = VALID ? head_w[9]   : 1'b0;
  assign FRAME_ERR = frame_err_q;
  assign OVERFLOW  = overflow_q;
  assign LEVEL     = level_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames, a monitor that
// collects accepted events and FRAME_ERR pulses, and one task per scenario.
module tb_ps2_rx_fifo;
  localparam int CLK_DIV    = 4;
  localparam int FILTER_LEN = 2;
  localparam int TIMEOUT    = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int AW         = 3;
  localparam int HALF       = 24;  // CLK cycles per PS/2 half period (6 ticks)

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          ready = 1'b0;
  logic [7:0]    key_code;
  logic          key_ext;
  logic          key_brk;
  logic          valid;
  logic          frame_err;
  logic          overflow;
  logic [AW:0]   level;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  int max_level = 0;
  logic [9:0] ev_q[$];

  ps2_rx_fifo #(
    .CLK_DIV(CLK_DIV), .FILTER_LEN(FILTER_LEN),
    .TIMEOUT(TIMEOUT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLK(clk), .RST(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .KEY_CODE(key_code), .KEY_EXT(key_ext), .KEY_BRK(key_brk),
    .VALID(valid), .READY(ready), .FRAME_ERR(frame_err),
    .OVERFLOW(overflow), .LEVEL(level)
  );

  always #5 clk = ~clk;

  // Monitor on the falling edge: record handshakes, error pulses and peak level.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_cnt++;
      if (valid && ready) begin
        ev_q.push_back({key_ext, key_brk, key_code});
        $display("event: ext=%0b brk=%0b code=%02h level=%0d", key_ext, key_brk, key_code, level);
      end
      if (int'(level) > max_level) max_level = int'(level);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flip_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ flip_par);
    ps2_bit(1'b1);
    wait_clk(2 * HALF);
  endtask

  // Start bit plus n data bits, then the clock is left high.
  task automatic send_partial(input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(i[0]);
    ps2_data = 1'b1;
  endtask

  task automatic clear_mon();
    err_cnt = 0;
    max_level = 0;
    ev_q.delete();
  endtask

  function automatic logic [9:0] ev_at(input int i);
    if (i < ev_q.size()) return ev_q[i];
    return 10'h3FF;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(5);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if ({frame_err, overflow} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {frame_err, overflow}); end
    total++; if ({key_ext, key_brk, key_code} !== 10'h000) begin bad++; $display("FAIL reset_key: got %h want 000", {key_ext, key_brk, key_code}); end
    rst = 1'b0;
    wait_clk(10);
    $display("test_reset done");
  endtask

  task automatic test_single();
    ready = 1'b1;
    clear_mon();
    send_byte(8'h1C, 1'b0);
    total++; if (ev_q.size() !== 1) begin bad++; $display("FAIL t1_count: got %0d want 1", ev_q.size()); end
    total++; if (ev_at(0) !== 10'h01C) begin bad++; $display("FAIL t1_event: got %h want 01C", ev_at(0)); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL t1_err: got %0d want 0", err_cnt); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL t1_level: got %0d want 0", level); end
  endtask

  task automatic test_prefix();
    clear_mon();
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h74, 1'b0);
    total++; if (ev_q.size() !== 1) begin bad++; $display("FAIL t2_count: got %0d want 1", ev_q.size()); end
    total++; if (ev_at(0) !== 10'h374) begin bad++; $display("FAIL t2_event: got %h want 374", ev_at(0)); end
    total++; if (max_level !== 1) begin bad++; $display("FAIL t2_peak_level: got %0d want 1", max_level); end
  endtask

  task automatic test_parity();
    clear_mon();
    send_byte(8'h1C, 1'b1);
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL t3_err: got %0d want 1", err_cnt); end
    total++; if (ev_q.size() !== 0) begin bad++; $display("FAIL t3_no_event: got %0d want 0", ev_q.size()); end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    total++; if (ev_at(0) !== 10'h11C) begin bad++; $display("FAIL t3_event: got %h want 11C", ev_at(0)); end
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL t3_err_after: got %0d want 1", err_cnt); end
  endtask

  task automatic test_timeout();
    clear_mon();
    send_partial(4);
    wait_clk(CLK_DIV * (TIMEOUT + 8));
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL t4_err: got %0d want 1", err_cnt); end
    total++; if (ev_q.size() !== 0) begin bad++; $display("FAIL t4_no_event: got %0d want 0", ev_q.size()); end
    send_byte(8'h15, 1'b0);
    total++; if (ev_at(0) !== 10'h015) begin bad++; $display("FAIL t4_event: got %h want 015", ev_at(0)); end
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL t4_err_after: got %0d want 1", err_cnt); end
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    clear_mon();
    for (int c = 1; c <= FIFO_DEPTH + 1; c++) send_byte(8'(c), 1'b0);
    total++; if (level !== 4'd8) begin bad++; $display("FAIL t5_level_full: got %0d want 8", level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL t5_overflow: got %b want 1", overflow); end
    total++; if ({valid, key_code} !== 9'h101) begin bad++; $display("FAIL t5_head: got %h want 101", {valid, key_code}); end
    ready = 1'b1;
    wait_clk(30);
    total++; if (ev_q.size() !== FIFO_DEPTH) begin bad++; $display("FAIL t5_drain_count: got %0d want 8", ev_q.size()); end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      total++;
      if (ev_at(i) !== {2'b00, 8'(i + 1)}) begin
        bad++; $display("FAIL t5_drain_%0d: got %h want %h", i, ev_at(i), {2'b00, 8'(i + 1)});
      end
    end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL t5_level_empty: got %0d want 0", level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL t5_overflow_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_glitch();
    clear_mon();
    ps2_data = 1'b0;
    wait_clk(20);
    ps2_clk = 1'b0;
    wait_clk(CLK_DIV);
    ps2_clk = 1'b1;
    wait_clk(20);
    ps2_data = 1'b1;
    wait_clk(20);
    send_byte(8'h1C, 1'b0);
    total++; if (ev_q.size() !== 1) begin bad++; $display("FAIL t6_glitch_count: got %0d want 1", ev_q.size()); end
    total++; if (ev_at(0) !== 10'h01C) begin bad++; $display("FAIL t6_glitch_event: got %h want 01C", ev_at(0)); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL t6_glitch_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_rst_mid_frame();
    send_byte(8'hE0, 1'b0);
    send_partial(3);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(10);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL t6_rst_overflow: got %b want 0", overflow); end
    clear_mon();
    send_byte(8'h2A, 1'b0);
    total++; if (ev_q.size() !== 1) begin bad++; $display("FAIL t6_rst_count: got %0d want 1", ev_q.size()); end
    total++; if (ev_at(0) !== 10'h02A) begin bad++; $display("FAIL t6_rst_event: got %h want 02A", ev_at(0)); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL t6_rst_err: got %0d want 0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_timeout();
    test_overflow();
    test_glitch();
    test_rst_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
